regfile_sb: RTL

- Parametrised general-purpose register file for the picoMIPS datapath. Generalises width, depth and the zero-register option.
- Adds write-bypass, asynchronous clear, and a per-register busy scoreboard for multi-cycle units (multiplier, memory).
- Sits between decode and the ALU. Decode issues destination reservations; write-back retires them. The stall output holds the PC/IR.

---
 rtl/picomips_pkg.sv | 8 +
 rtl/rf_scoreboard.sv | 47 ++++
 rtl/regfile_sb.sv | 38 +++
 3 files changed

// File: rtl/picomips_pkg.sv
// picomips_pkg: shared datapath widths and register-file types
package picomips_pkg;
  localparam int DATA_W = 8;
  localparam int NREG = 8;
  localparam int AW = $clog2(NREG);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, pending count, WAW flag and source stall
module rf_scoreboard #(
  parameter int NREG = picomips_pkg::NREG,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREG),
  localparam int PW = AW + 1
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          w,
  input  logic [AW-1:0] Waddr,
  input  logic          issue,
  input  logic [AW-1:0] Iaddr,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  output logic          stall,
  output logic [PW-1:0] pending,
  output logic          waw_err
);
  logic [NREG-1:0] busy, keep, set_v, clr_v;
  logic inc, dec, waw, s1, s2;
  always_comb begin
    keep = '1;
    keep[0] = !ZERO_R0;
    set_v = (NREG'(issue) << Iaddr) & keep;
    clr_v = (NREG'(w) << Waddr) & keep;
    inc = |(set_v & ~busy);
    dec = |(clr_v & busy & ~set_v);
    waw = |(set_v & busy & ~clr_v);
    // a port being written this cycle is already satisfied by the bypass
    s1 = busy[Raddr1] && !(BYPASS && w && Raddr1 == Waddr);
    s2 = busy[Raddr2] && !(BYPASS && w && Raddr2 == Waddr);
    stall = s1 || s2;
  end
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      busy <= '0;
      pending <= '0;
      waw_err <= 1'b0;
    end else begin
      busy <= (busy & ~clr_v) | set_v;
      pending <= pending + PW'(inc) - PW'(dec);
      waw_err <= waw_err | waw;
    end
  assert property (@(posedge clk) disable iff (!nReset) int'(pending) == $countones(busy));
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with write bypass and busy scoreboard
module regfile_sb #(
  parameter int N = picomips_pkg::DATA_W,
  parameter int NREG = picomips_pkg::NREG,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS = 1'b1,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          w,
  input  logic [AW-1:0] Waddr,
  input  logic [N-1:0]  Wdata,
  input  logic [AW-1:0] Raddr1,
  input  logic [AW-1:0] Raddr2,
  output logic [N-1:0]  Rdata1,
  output logic [N-1:0]  Rdata2,
  input  logic          issue,
  input  logic [AW-1:0] Iaddr,
  output logic          stall,
  output logic [AW:0]   pending,
  output logic          waw_err
);
  logic [N-1:0] gpr [NREG];
  always_ff @(posedge clk or negedge nReset)
    if (!nReset)
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    else if (w && !(ZERO_R0 && Waddr == '0))
      gpr[Waddr] <= Wdata;
  always_comb begin
    Rdata1 = (ZERO_R0 && Raddr1 == '0) ? '0 : (BYPASS && w && Raddr1 == Waddr) ? Wdata : gpr[Raddr1];
    Rdata2 = (ZERO_R0 && Raddr2 == '0) ? '0 : (BYPASS && w && Raddr2 == Waddr) ? Wdata : gpr[Raddr2];
  end
  rf_scoreboard #(.NREG(NREG), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)) u_sb (
    .clk(clk), .nReset(nReset), .w(w), .Waddr(Waddr), .issue(issue), .Iaddr(Iaddr),
    .Raddr1(Raddr1), .Raddr2(Raddr2), .stall(stall), .pending(pending), .waw_err(waw_err)
  );
endmodule
